// File: rtl/book_drain_scheduler.sv
// ---------------------------------------------------------------------------
// book_drain_scheduler
//
// Paced read controller between the parser message FIFO and the order book.
// It issues single-cycle read pulses, waits a settle interval after each read
// so the order book can absorb the update, and forces a cooldown after a
// burst of back-to-back reads, unless the FIFO is full (then the burst limit
// is bypassed so the parser is not back-pressured). It supports free-running
// drain (run_en level) and single-step mode (step_req pulse while run_en=0).
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-low reset
//   run_en       in   level, 1 = free-running drain
//   step_req     in   one-cycle pulse, requests one read while run_en=0
//   fifo_empty   in   parser FIFO empty flag
//   fifo_full    in   parser FIFO full flag
//   read_en      out  one-cycle read pulse to FIFO and order book
//   busy         out  high in any state other than IDLE
//   state_out    out  state encoding (IDLE=0, ISSUE=1, SETTLE=2, COOLDOWN=3)
//   msg_count    out  total reads issued, saturating at all-ones
//   step_pending out  latched step request not yet served
//
// Optional build macro DRAIN_STALL_STATS_EN adds two saturating counters:
//   stall_cycles     out  cycles with fifo_full=1 and no read issued
//   burst_cut_count  out  number of SETTLE-to-COOLDOWN transitions
// ---------------------------------------------------------------------------
module book_drain_scheduler #(
   parameter int SETTLE_CYCLES   = 2,
   parameter int BURST_LEN       = 4,
   parameter int COOLDOWN_CYCLES = 3,
   parameter int CNT_W           = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run_en,
   input  logic             step_req,
   input  logic             fifo_empty,
   input  logic             fifo_full,
   output logic             read_en,
   output logic             busy,
   output logic [1:0]       state_out,
   output logic [CNT_W-1:0] msg_count,
   output logic             step_pending
`ifdef DRAIN_STALL_STATS_EN
   ,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] burst_cut_count
`endif
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      SETTLE   = 2'd2,
      COOLDOWN = 2'd3
   } state_t;

   // Timers hold "cycles remaining minus one", so the load values are N-1
   // and the decision is taken in the cycle where the timer reads zero.
   localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
   localparam logic [3:0]       COOL_LOAD   = 4'(COOLDOWN_CYCLES - 1);
   localparam logic [3:0]       BURST_LIMIT = 4'(BURST_LEN);
   localparam logic [3:0]       BURST_SAT   = 4'd15;
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   state_t     state;
   logic [3:0] timer;
   logic [3:0] burst_cnt;

   logic idle_go;
   logic settle_done;
   logic settle_issue;
   logic settle_cut;
   logic enter_issue;

   // Outputs are plain decodes of the state flop, so reset removes a read
   // pulse in the same cycle it is asserted.
   assign read_en   = (state == ISSUE);
   assign busy      = (state != IDLE);
   assign state_out = state;

   // Decision terms for the IDLE and SETTLE exits. A full FIFO overrides the
   // burst limit; an empty FIFO or a dropped run_en always ends the burst.
   always_comb begin
      idle_go      = 1'b0;
      settle_done  = 1'b0;
      settle_issue = 1'b0;
      settle_cut   = 1'b0;
      enter_issue  = 1'b0;

      idle_go      = !fifo_empty && (run_en || step_pending);
      settle_done  = (timer == 4'd0);
      settle_issue = settle_done && run_en && !fifo_empty &&
                     (fifo_full || (burst_cnt < BURST_LIMIT));
      settle_cut   = settle_done && run_en && !fifo_empty && !fifo_full &&
                     (burst_cnt >= BURST_LIMIT);
      enter_issue  = ((state == IDLE) && idle_go) ||
                     ((state == SETTLE) && settle_issue);
   end

   // Main sequencer: state, settle/cooldown timer, burst length, message
   // count and the latched step request all move together here.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         timer        <= 4'd0;
         burst_cnt    <= 4'd0;
         msg_count    <= '0;
         step_pending <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (idle_go) begin
                  state <= ISSUE;
               end
            end

            ISSUE: begin
               if (msg_count != CNT_MAX) begin
                  msg_count <= msg_count + 1'b1;
               end
               if (burst_cnt != BURST_SAT) begin
                  burst_cnt <= burst_cnt + 4'd1;
               end
               timer <= SETTLE_LOAD;
               state <= SETTLE;
            end

            SETTLE: begin
               if (!settle_done) begin
                  timer <= timer - 4'd1;
               end else if (settle_issue) begin
                  state <= ISSUE;
               end else if (settle_cut) begin
                  timer <= COOL_LOAD;
                  state <= COOLDOWN;
               end else begin
                  burst_cnt <= 4'd0;
                  state     <= IDLE;
               end
            end

            COOLDOWN: begin
               // A full FIFO cuts the cooldown short so draining resumes.
               if (fifo_full || (timer == 4'd0)) begin
                  burst_cnt <= 4'd0;
                  state     <= IDLE;
               end else begin
                  timer <= timer - 4'd1;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase

         // Entering ISSUE serves the request; a new step_req in that very
         // cycle is dropped because the clear takes priority.
         if (enter_issue) begin
            step_pending <= 1'b0;
         end else if (step_req && !run_en) begin
            step_pending <= 1'b1;
         end
      end
   end

`ifdef DRAIN_STALL_STATS_EN
   // Stall statistics: cycles the FIFO sat full without being read, and the
   // number of bursts cut short by the mandatory cooldown.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cycles    <= '0;
         burst_cut_count <= '0;
      end else begin
         if (fifo_full && !read_en && (stall_cycles != CNT_MAX)) begin
            stall_cycles <= stall_cycles + 1'b1;
         end
         if ((state == SETTLE) && settle_cut && (burst_cut_count != CNT_MAX)) begin
            burst_cut_count <= burst_cut_count + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_book_drain_scheduler.sv
// ---------------------------------------------------------------------------
// tb_book_drain_scheduler
//
// Self-checking bench for book_drain_scheduler. A small FIFO occupancy model
// drives fifo_empty/fifo_full; a timestamp-based reference model predicts
// every output each cycle from the scheduling rules (read spacing, burst
// limit, cooldown, step requests). The counter width is reduced so that the
// msg_count saturation boundary is reachable in a short run.
// ---------------------------------------------------------------------------
module tb_book_drain_scheduler;

   localparam int S    = 2;
   localparam int B    = 4;
   localparam int C    = 3;
   localparam int W    = 6;
   localparam int CMAX = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         reset;
   logic         run_en;
   logic         step_req;
   logic         fifo_empty;
   logic         fifo_full;
   logic         read_en;
   logic         busy;
   logic [1:0]   state_out;
   logic [W-1:0] msg_count;
   logic         step_pending;
`ifdef DRAIN_STALL_STATS_EN
   logic [W-1:0] stall_cycles;
   logic [W-1:0] burst_cut_count;
`endif

   book_drain_scheduler #(
      .SETTLE_CYCLES   (S),
      .BURST_LEN       (B),
      .COOLDOWN_CYCLES (C),
      .CNT_W           (W)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .run_en          (run_en),
      .step_req        (step_req),
      .fifo_empty      (fifo_empty),
      .fifo_full       (fifo_full),
      .read_en         (read_en),
      .busy            (busy),
      .state_out       (state_out),
      .msg_count       (msg_count),
      .step_pending    (step_pending)
`ifdef DRAIN_STALL_STATS_EN
      ,
      .stall_cycles    (stall_cycles),
      .burst_cut_count (burst_cut_count)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Environment knobs, applied just after each rising edge.
   int fifo_count    = 0;
   int push_prob     = 0;
   int full_mode     = 0;
   int step_prob     = 0;
   int extra_push    = 0;
   bit run_knob      = 1'b0;
   bit run_rand      = 1'b0;
   bit step_force    = 1'b0;
   bit release_req   = 1'b0;
   bit dut_read_seen = 1'b0;
   int tick_no       = 0;
   int read_ticks[$];
   int exp_ticks[$];

   // Reference model: timestamps of the scheduled read, settle decision and
   // cooldown window rather than a state register.
   int cyc        = 0;
   int next_read;
   int last_read;
   int decide_at;
   int cool_start;
   int cool_end;
   int burst;
   int m_count;
   bit m_pend;
   int m_stall;
   int m_cut;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   function automatic void modelReset();
      next_read  = -1;
      last_read  = -100;
      decide_at  = -100;
      cool_start = -100;
      cool_end   = -100;
      burst      = 0;
      m_count    = 0;
      m_pend     = 1'b0;
      m_stall    = 0;
      m_cut      = 0;
   endfunction

   task automatic checkResetValues(input string pfx);
      checkOutput({pfx, "_read_en"}, 32'(read_en), 0);
      checkOutput({pfx, "_busy"}, 32'(busy), 0);
      checkOutput({pfx, "_state"}, 32'(state_out), 0);
      checkOutput({pfx, "_msg_count"}, 32'(msg_count), 0);
      checkOutput({pfx, "_step_pending"}, 32'(step_pending), 0);
`ifdef DRAIN_STALL_STATS_EN
      checkOutput({pfx, "_stall"}, 32'(stall_cycles), 0);
      checkOutput({pfx, "_cut"}, 32'(burst_cut_count), 0);
`endif
   endtask

   // Predict this cycle's outputs, compare, then advance using the inputs
   // that the next rising edge will sample.
   task automatic modelStep();
      bit rd;
      bit settling;
      bit cooling;
      bit goes;
      int exp_state;
      rd        = (cyc == next_read);
      settling  = !rd && (cyc > last_read) && (cyc <= decide_at);
      cooling   = (cyc >= cool_start) && (cyc <= cool_end);
      exp_state = rd ? 1 : settling ? 2 : cooling ? 3 : 0;
      goes      = 1'b0;

      checkOutput("read_en", 32'(read_en), 32'(rd));
      checkOutput("state_out", 32'(state_out), exp_state);
      checkOutput("busy", 32'(busy), 32'(exp_state != 0));
      checkOutput("msg_count", 32'(msg_count), m_count);
      checkOutput("step_pending", 32'(step_pending), 32'(m_pend));
`ifdef DRAIN_STALL_STATS_EN
      checkOutput("stall_cycles", 32'(stall_cycles), m_stall);
      checkOutput("burst_cut_count", 32'(burst_cut_count), m_cut);
`endif

      if (fifo_full && !rd && m_stall < CMAX) m_stall++;

      if (rd) begin
         if (m_count < CMAX) m_count++;
         if (burst < 15) burst++;
         last_read = cyc;
         decide_at = cyc + S;
      end else if (settling) begin
         if (cyc == decide_at) begin
            if (run_en && !fifo_empty && (fifo_full || burst < B)) begin
               next_read = cyc + 1;
               goes      = 1'b1;
            end else if (run_en && !fifo_empty) begin
               cool_start = cyc + 1;
               cool_end   = cyc + C;
               if (m_cut < CMAX) m_cut++;
            end else begin
               burst = 0;
            end
         end
      end else if (cooling) begin
         if (fifo_full || cyc == cool_end) begin
            cool_end = cyc;
            burst    = 0;
         end
      end else begin
         if (!fifo_empty && (run_en || m_pend)) begin
            next_read = cyc + 1;
            goes      = 1'b1;
         end
      end

      if (goes) m_pend = 1'b0;
      else if (step_req && !run_en) m_pend = 1'b1;
      cyc++;
   endtask

   // One clock cycle: update the FIFO model and drive inputs after the
   // rising edge, then check on the falling edge.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
      if (release_req) begin
         reset       = 1'b1;
         release_req = 1'b0;
      end
      if (dut_read_seen && fifo_count > 0) fifo_count--;
      fifo_count += extra_push;
      extra_push = 0;
      if (push_prob > 0 && int'($urandom_range(99)) < push_prob) fifo_count++;
      fifo_empty = (fifo_count == 0);
      if (full_mode == 1) fifo_full = 1'b1;
      else if (full_mode == 2) fifo_full = ($urandom_range(3) == 0);
      else fifo_full = 1'b0;
      if (run_rand && $urandom_range(19) == 0) run_knob = !run_knob;
      run_en     = run_knob;
      step_req   = step_force || (step_prob > 0 && int'($urandom_range(99)) < step_prob);
      step_force = 1'b0;
      @(negedge clk);
      if (reset) modelStep();
      else begin
         modelReset();
         checkResetValues("rst");
      end
      dut_read_seen = read_en;
      if (read_en) read_ticks.push_back(tick_no);
      tick_no++;
   endtask

   // Assert reset between edges and confirm the outputs clear at once.
   task automatic assertResetAsync();
      #2;
      reset = 1'b0;
      #1;
      checkResetValues("async");
      dut_read_seen = 1'b0;
      modelReset();
   endtask

   task automatic doReset();
      assertResetAsync();
      applyStimulus();
      applyStimulus();
      release_req = 1'b1;
      applyStimulus();
   endtask

   task automatic checkReadTicks(input string tag);
      checkOutput({tag, "_nreads"}, read_ticks.size(), exp_ticks.size());
      for (int i = 0; i < exp_ticks.size(); i++) begin
         checkOutput($sformatf("%s_read%0d", tag, i),
                     (i < read_ticks.size()) ? read_ticks[i] : -1, exp_ticks[i]);
      end
   endtask

   task automatic startDrain();
      read_ticks.delete();
      tick_no  = 0;
      run_knob = 1'b1;
   endtask

   initial begin
      bit found;
      int rst_at;
      reset      = 1'b0;
      run_en     = 1'b0;
      step_req   = 1'b0;
      fifo_empty = 1'b1;
      fifo_full  = 1'b0;
      modelReset();
      applyStimulus();
      applyStimulus();
      release_req = 1'b1;
      applyStimulus();

      // Three queued messages, default pacing: reads 3 cycles apart.
      $display("[TB] scenario: three-message drain");
      extra_push = 3;
      applyStimulus();
      startDrain();
      repeat (15) applyStimulus();
      exp_ticks = '{1, 4, 7};
      checkReadTicks("drain3");
      checkOutput("drain3_count", 32'(msg_count), 3);
      checkOutput("drain3_busy", 32'(busy), 0);

      // Six messages: the fifth read waits out the cooldown, then the IDLE
      // decision cycle, so it lands at 10 + settle(2) + cooldown(3) + 2.
      $display("[TB] scenario: burst limit and cooldown");
      run_knob = 1'b0;
      doReset();
      extra_push = 6;
      applyStimulus();
      startDrain();
      repeat (30) applyStimulus();
      exp_ticks = '{1, 4, 7, 10, 17, 20};
      checkReadTicks("burst6");
      checkOutput("burst6_count", 32'(msg_count), 6);
      checkOutput("burst6_state", 32'(state_out), 0);

      // Full FIFO bypasses the burst limit: eight evenly spaced reads.
      $display("[TB] scenario: full FIFO bypass");
      run_knob  = 1'b0;
      full_mode = 1;
      doReset();
      extra_push = 8;
      applyStimulus();
      startDrain();
      repeat (30) applyStimulus();
      exp_ticks.delete();
      for (int i = 0; i < 8; i++) exp_ticks.push_back(1 + 3 * i);
      checkReadTicks("full8");
      checkOutput("full8_count", 32'(msg_count), 8);

      // Step request while empty is latched, served once data arrives.
      $display("[TB] scenario: single step");
      full_mode = 0;
      run_knob  = 1'b0;
      doReset();
      read_ticks.delete();
      step_force = 1'b1;
      repeat (3) applyStimulus();
      checkOutput("step_pend_latched", 32'(step_pending), 1);
      checkOutput("step_no_read", read_ticks.size(), 0);
      extra_push = 1;
      repeat (8) applyStimulus();
      checkOutput("step_nreads", read_ticks.size(), 1);
      checkOutput("step_pend_clear", 32'(step_pending), 0);
      checkOutput("step_count", 32'(msg_count), 1);
      checkOutput("step_idle", 32'(state_out), 0);

      // Reset in SETTLE after two reads, then restart one cycle after release.
      $display("[TB] scenario: reset during settle");
      doReset();
      extra_push = 5;
      applyStimulus();
      startDrain();
      repeat (6) applyStimulus();
      checkOutput("settle_reads", read_ticks.size(), 2);
      checkOutput("settle_state", 32'(state_out), 2);
      assertResetAsync();
      applyStimulus();
      release_req = 1'b1;
      read_ticks.delete();
      tick_no = 0;
      repeat (5) applyStimulus();
      checkOutput("restart_first_read", (read_ticks.size() > 0) ? read_ticks[0] : -1, 1);

      // Reset landing on a read pulse removes it before the clock edge.
      $display("[TB] scenario: reset during issue");
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         applyStimulus();
         if (read_en) found = 1'b1;
      end
      checkOutput("issue_found", 32'(found), 1);
      assertResetAsync();
      applyStimulus();
      release_req = 1'b1;
      applyStimulus();
      repeat (10) applyStimulus();

      // Counter saturation at all-ones.
      $display("[TB] scenario: msg_count saturation");
      run_knob  = 1'b0;
      full_mode = 1;
      fifo_count = 0;
      doReset();
      extra_push = CMAX + 5;
      applyStimulus();
      startDrain();
      repeat (3 * (CMAX + 5) + 10) applyStimulus();
      checkOutput("sat_count", 32'(msg_count), CMAX);
      checkOutput("sat_reads", read_ticks.size(), CMAX + 5);

      // Randomised traffic with occasional asynchronous resets.
      $display("[TB] scenario: random traffic");
      run_knob  = 1'b0;
      full_mode = 2;
      run_rand  = 1'b1;
      for (int seg = 0; seg < 6; seg++) begin
         push_prob = int'($urandom_range(5, 60));
         step_prob = int'($urandom_range(0, 15));
         rst_at    = int'($urandom_range(50, 250));
         for (int i = 0; i < 300; i++) begin
            applyStimulus();
            if (i == rst_at) begin
               assertResetAsync();
               applyStimulus();
               release_req = 1'b1;
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
